// File: rtl/pio_poll_pkg.sv
// Shared types and constants for the input-PIO polling controller.
package pio_poll_pkg;

  typedef enum logic [1:0] {
    ST_COUNT  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LATCH  = 2'd2
  } poll_state_e;

  localparam logic [1:0]  ADDR_DATA  = 2'd0;
  localparam logic [1:0]  ADDR_IDLE  = 2'd3;
  localparam int unsigned MIN_PERIOD = 3;
  localparam int unsigned TS_W       = 16;

endpackage

// File: rtl/pio_poll_fifo.sv
// Show-ahead FIFO for polled samples; DEPTH must be a power of two so the
// pointers wrap naturally.
module pio_poll_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  import pio_poll_pkg::*;

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      level_d = level_q + LVL_W'(1);
    else if (!push_ok && pop_ok) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr_q];
  assign level     = level_q;

endmodule

// File: rtl/pio_poll_ctrl.sv
// pio_poll_ctrl: polls an input-PIO slave every max(period,3) cycles and queues
// changed samples. Define POLL_TIMESTAMP_EN to tag each entry with a cycle count.
module pio_poll_ctrl
  import pio_poll_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [PERIOD_W-1:0]      period,
  output logic [1:0]               pio_address,
  input  logic [31:0]              pio_readdata,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [TS_W-1:0]          out_ts,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [$clog2(DEPTH):0]   level
);

`ifdef POLL_TIMESTAMP_EN
  localparam int ENTRY_W = DATA_W + TS_W;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  poll_state_e         state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_valid_q, prev_valid_d;
  logic                ovf_q, ovf_d;
  logic [PERIOD_W-1:0] reload;
  logic [DATA_W-1:0]   sample;
  logic                push;
  logic                fifo_empty, fifo_full;
  logic [ENTRY_W-1:0]  push_entry, head_entry;

  assign sample = pio_readdata[DATA_W-1:0];

  generate
    if (DATA_W < 32) begin : g_unused
      logic unused_rd_hi;
      assign unused_rd_hi = ^pio_readdata[31:DATA_W];
    end
  endgenerate

  // COUNT spans reload+1 cycles, so the full interval is max(period,3).
  assign reload = (period < PERIOD_W'(MIN_PERIOD)) ? '0 : period - PERIOD_W'(MIN_PERIOD);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    push         = 1'b0;
    if (!enable) begin
      state_d      = ST_COUNT;
      cnt_d        = reload;
      prev_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_COUNT: begin
          if (cnt_q == '0) state_d = ST_SETTLE;
          else             cnt_d   = cnt_q - PERIOD_W'(1);
        end
        ST_SETTLE: state_d = ST_LATCH;
        ST_LATCH: begin
          state_d      = ST_COUNT;
          cnt_d        = reload;
          prev_d       = sample;
          prev_valid_d = 1'b1;
          push         = !prev_valid_q || (sample != prev_q);
        end
        default: state_d = ST_COUNT;
      endcase
    end
  end

  // Drop only when the entry cannot fit even after a same-cycle pop; set beats clear.
  assign ovf_d = (push && fifo_full && !(out_ready && !fifo_empty)) || (ovf_q && !clr_ovf);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_COUNT;
      cnt_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign pio_address = (state_q == ST_SETTLE || state_q == ST_LATCH) ? ADDR_DATA : ADDR_IDLE;

`ifdef POLL_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  assign ts_d = ts_q + TS_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_d;
  end

  assign push_entry = {ts_q, sample};
  assign out_data   = head_entry[DATA_W-1:0];
  assign out_ts     = head_entry[ENTRY_W-1:DATA_W];
`else
  assign push_entry = sample;
  assign out_data   = head_entry;
  assign out_ts     = '0;
`endif

  pio_poll_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (out_ready),
    .head_data (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (level)
  );

  assign out_valid = !fifo_empty;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pio_poll_ctrl.sv
// Bench for pio_poll_ctrl: directed scenarios plus random stimulus, all checked
// against an interval/queue reference model of the poller.
module tb_pio_poll_ctrl;

  localparam int PERIOD_W = 16;
  localparam int DEPTH    = 4;
  localparam int DATA_W   = 8;
  localparam int LVL_W    = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                enable = 1'b0;
  logic [PERIOD_W-1:0] period = '0;
  logic [1:0]          pio_address;
  logic [31:0]         pio_readdata = '0;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                out_ready = 1'b0;
  logic [15:0]         out_ts;
  logic                overflow;
  logic                clr_ovf = 1'b0;
  logic [LVL_W-1:0]    level;
  logic [DATA_W-1:0]   pio_in = '0;

  int n_checks = 0;
  int n_fail   = 0;

  pio_poll_ctrl #(
    .PERIOD_W (PERIOD_W),
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .period       (period),
    .pio_address  (pio_address),
    .pio_readdata (pio_readdata),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .out_ts       (out_ts),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf),
    .level        (level)
  );

  always #5 clk = ~clk;

  // Input-PIO slave: registered readdata, distinct junk when not addressing data.
  always @(posedge clk)
    pio_readdata <= (pio_address == 2'd0) ? {24'h5C5C5C, pio_in} : {24'hA3A3A3, ~pio_in};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: m_rem = cycles until the next sample instant (1 = sampling now).
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [15:0]       ts;
  } entry_t;

  entry_t            m_q[$];
  int                m_rem;
  logic [DATA_W-1:0] m_prev, m_settle;
  bit                m_prev_valid, m_ovf;
  logic [15:0]       m_ts;

  function automatic int eff(input logic [PERIOD_W-1:0] p);
    return (p < 3) ? 3 : int'(p);
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_rem        = 3;
    m_prev       = '0;
    m_settle     = '0;
    m_prev_valid = 1'b0;
    m_ovf        = 1'b0;
    m_ts         = '0;
  endfunction

  task automatic model_step();
    bit     pop, do_push, drop;
    entry_t e;
    pop     = out_ready && (m_q.size() != 0);
    do_push = 1'b0;
    drop    = 1'b0;
    e.ts    = m_ts;
    e.data  = '0;
    if (!enable) begin
      m_prev_valid = 1'b0;
      m_rem        = eff(period);
    end else if (m_rem == 1) begin
      do_push      = !m_prev_valid || (m_settle != m_prev);
      e.data       = m_settle;
      m_prev       = m_settle;
      m_prev_valid = 1'b1;
      m_rem        = eff(period);
    end else begin
      if (m_rem == 2) m_settle = pio_in;
      m_rem--;
    end
    if (pop) void'(m_q.pop_front());
    if (do_push) begin
      if (m_q.size() < DEPTH) m_q.push_back(e);
      else                    drop = 1'b1;
    end
    if (drop)         m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    m_ts = m_ts + 16'd1;
  endtask

  always @(posedge clk) if (reset_n) model_step();

  always @(negedge clk) begin
    if (reset_n) begin
      check("addr",  pio_address, (m_rem <= 2) ? 32'd0 : 32'd3);
      check("valid", out_valid, m_q.size() != 0);
      check("level", level, m_q.size());
      check("data",  out_data, (m_q.size() != 0) ? m_q[0].data : '0);
`ifdef POLL_TIMESTAMP_EN
      check("ts",    out_ts, (m_q.size() != 0) ? m_q[0].ts : '0);
`else
      check("ts",    out_ts, 0);
`endif
      check("ovf",   overflow, m_ovf);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rem(input int target);
    for (int i = 0; i < 64; i++) begin
      if (m_rem == target) return;
      @(negedge clk);
    end
    check("wait_phase_timeout", m_rem, target);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (m_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_level", level, 0);
    out_ready = 1'b0;
  endtask

  // Change the input only during SETTLE so each new value is sampled exactly once.
  task automatic fill_to(input int target);
    for (int i = 0; i < 200; i++) begin
      if (m_q.size() >= target) return;
      if (m_rem == 2) pio_in = pio_in + 1'b1;
      @(negedge clk);
    end
    check("fill_timeout", m_q.size(), target);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_data",  out_data, 0);
    check("rst_ts",    out_ts, 0);
    check("rst_ovf",   overflow, 0);
    check("rst_addr",  pio_address, 3);
    cycles(2);
    reset_n = 1'b1;
  endtask

  task automatic count_addr0(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (pio_address == 2'd0) cnt++;
    end
  endtask

  initial begin
    int n0;
    logic [DATA_W-1:0] tail_v;
    logic [15:0] t0, t1, t2, dt;

    model_reset();
    enable = 1'b1;
    period = 16'd10;
    pio_in = 8'h5A;
    @(negedge clk);
    apply_reset();

    // Constant input: one entry only; a change adds exactly one more.
    cycles(35);
    check("p10_level_const", level, 1);
    check("p10_head", out_data, 8'h5A);
    pio_in = 8'hA5;
    cycles(20);
    check("p10_level_change", level, 2);
    count_addr0(40, n0);
    check("p10_addr0_per_40", n0, 8);

    // Periods below the minimum clamp to a 3-cycle interval.
    period = 16'd0;
    cycles(12);
    count_addr0(30, n0);
    check("p0_addr0_per_30", n0, 20);
    period = 16'd1;
    cycles(6);
    count_addr0(30, n0);
    check("p1_addr0_per_30", n0, 20);

    // Overflow: six distinct samples into a 4-deep FIFO with no consumer.
    drain();
    period = 16'd3;
    for (int i = 0; i < 18; i++) begin
      pio_in = pio_in + 1'b1;
      @(negedge clk);
    end
    check("ovf_level", level, 4);
    check("ovf_set", overflow, 1);
    wait_rem(3);
    clr_ovf = 1'b1;
    cycles(1);
    clr_ovf = 1'b0;
    check("ovf_clr", overflow, 0);
    pio_in = pio_in + 1'b1;
    cycles(1);
    clr_ovf = 1'b1;
    cycles(1);
    clr_ovf = 1'b0;
    check("ovf_set_wins", overflow, 1);

    // Full FIFO: push and pop together keep the level and append the new value.
    wait_rem(2);
    pio_in = pio_in + 1'b1;
    tail_v = pio_in;
    cycles(1);
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    check("full_pushpop_level", level, 4);
    out_ready = 1'b1;
    cycles(3);
    out_ready = 1'b0;
    check("full_pushpop_tail", out_data, tail_v);
    check("full_pushpop_left", level, 1);

    // Enable drop during SETTLE aborts the sample; re-enable re-arms one push.
    wait_rem(2);
    enable = 1'b0;
    cycles(1);
    check("abort_addr", pio_address, 3);
    check("abort_level", level, 1);
    enable = 1'b1;
    cycles(8);
    check("reenable_level", level, 2);
    cycles(9);
    check("reenable_once", level, 2);

    // Reset asserted in the middle of LATCH with three entries queued.
    drain();
    fill_to(3);
    wait_rem(1);
    check("pre_rst_level", level, 3);
    period = 16'd5;
    apply_reset();

    // Consecutive entries taken every 5 cycles carry timestamps 5 apart.
    drain();
    fill_to(3);
    t0 = out_ts;
    out_ready = 1'b1; cycles(1); out_ready = 1'b0;
    t1 = out_ts;
    out_ready = 1'b1; cycles(1); out_ready = 1'b0;
    t2 = out_ts;
`ifdef POLL_TIMESTAMP_EN
    dt = t1 - t0;
    check("ts_delta_1", dt, 5);
    dt = t2 - t1;
    check("ts_delta_2", dt, 5);
`else
    dt = t0 | t1 | t2;
    check("ts_tied_zero", dt, 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      enable    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) period = PERIOD_W'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0)  pio_in = DATA_W'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 2) == 0);
      clr_ovf   = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    clr_ovf = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_poll_ctrl.md
PIO_POLL_CTRL -- requirements
Module: pio_poll_ctrl

Interface
REQ-001 SHALL have parameter PERIOD_W, default 16, width of poll-interval input.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter DATA_W, default 8, sampled bits, taken from pio_readdata[DATA_W-1:0].
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  in  1  polling enable.
REQ-007 SHALL have port period  in  PERIOD_W  poll interval in clk cycles.
REQ-008 SHALL have port pio_address  out  2  address to the input-PIO slave.
REQ-009 SHALL have port pio_readdata  in  32  registered readdata from the PIO slave, 1-cycle latency.
REQ-010 SHALL have port out_valid  out  1  FIFO head valid.
REQ-011 SHALL have port out_data  out  DATA_W  FIFO head sample (show-ahead).
REQ-012 SHALL have port out_ready  in  1  consumer pop; pop occurs when out_valid && out_ready.
REQ-013 SHALL have port out_ts  out  16  FIFO head timestamp.
REQ-014 SHALL have port overflow  out  1  sticky dropped-sample flag.
REQ-015 SHALL have port clr_ovf  in  1  clears overflow.
REQ-016 SHALL have port level  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 SHALL run FSM COUNT -> SETTLE -> LATCH -> COUNT; COUNT lasts max(period,3)-2 cycles, SETTLE 1, LATCH 1; one sample per max(period,3) cycles.
REQ-018 SHALL drive pio_address=0 in SETTLE and LATCH, 3 otherwise.
REQ-019 SHALL capture pio_readdata[DATA_W-1:0] in LATCH (slave has registered address-0 data by then).
REQ-020 SHALL push the sample when it differs from the previous latched sample, or when no previous sample exists since reset/enable rise; prev updated every LATCH.
REQ-021 SHALL, on push with FIFO full and no pop same cycle, drop the sample and set overflow; push+pop when full both succeed, level unchanged.
REQ-022 SHALL ignore out_ready when empty; push to empty FIFO gives out_valid=1 next cycle.
REQ-023 SHALL hold overflow until clr_ovf; set wins over simultaneous clr_ovf.
REQ-024 SHALL, while enable=0, hold FSM in COUNT with counter reloaded, pio_address=3, no pushes, clear prev-valid; FIFO still drains.
REQ-025 SHALL abort an in-flight SETTLE/LATCH without push when enable falls.
REQ-026 SHALL sample period at entry to COUNT; changes take effect next interval.

Reset
REQ-027 SHALL on reset_n=0 asynchronously set FSM=COUNT, counter=0, pio_address=3, FIFO empty, level=0, out_valid=0, out_data=0, out_ts=0, overflow=0, prev-valid=0, timestamp=0.
REQ-028 SHALL resume polling first cycle after reset release if enable=1.

Configuration
REQ-029 SHALL with POLL_TIMESTAMP_EN defined keep a 16-bit free-running cycle counter (wraps 0xFFFF->0), store its value at LATCH with each pushed entry, present it on out_ts.
REQ-030 SHALL without POLL_TIMESTAMP_EN omit counter and timestamp storage, tie out_ts to 0.

Structure
REQ-031 SHALL place FSM state enum, ADDR_DATA=0, ADDR_IDLE=3, MIN_PERIOD=3 in package pio_poll_pkg.
REQ-032 SHALL implement FIFO as sub-module pio_poll_fifo (show-ahead, level, full/empty).

Verification
REQ-033 SHALL cover: period=10, input 0x5A constant -> exactly one entry 0x5A, next entry only after input change to 0xA5, samples 10 cycles apart.
REQ-034 SHALL cover: period=0 and 1 -> sample interval 3 cycles; pio_address=0 exactly 2 cycles in 3.
REQ-035 SHALL cover: DEPTH=4, out_ready=0, 6 distinct changes -> level=4, first 4 values retained, overflow=1; clr_ovf -> 0; set+clr same cycle -> 1.
REQ-036 SHALL cover: full FIFO, push and pop same cycle -> level stays 4, new value at tail.
REQ-037 SHALL cover: enable drop in SETTLE -> no push, pio_address=3 next cycle; re-enable with unchanged input -> one push.
REQ-038 SHALL cover: reset_n pulse mid-LATCH with FIFO level 3 -> all outputs reset values; with POLL_TIMESTAMP_EN, period=5 -> consecutive out_ts differ by 5 modulo 65536.
